// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx : pops words from a FIFO and sends each one as a UART frame
// Rev 1.0 ; optional even-parity bit enabled by FIFO_UART_TX_PARITY_EN
// ============================================================================
module fifo_uart_tx #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_read_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_idx_w = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_SIZE - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_stop   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] c_st_parity = 3'd3;
`endif

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [DATA_SIZE-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 w_tx_next;
  logic                 w_bit_end;
  logic                 w_take;
  logic                 w_after_data;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign w_bit_end = (r_cnt == c_cnt_last);
  // A new word is taken either from idle or in the last stop-bit cycle, so frames chain with no gap
  assign w_take    = !fifo_empty &&
                     ((r_state == c_st_idle) || ((r_state == c_st_stop) && w_bit_end));

`ifdef FIFO_UART_TX_PARITY_EN
  assign w_after_data = r_parity;
`else
  assign w_after_data = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:   if (w_take) w_state_next = c_st_start;
      c_st_start:  if (w_bit_end) w_state_next = c_st_data;
      c_st_data: begin
        if (w_bit_end && (r_idx == c_idx_last)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          w_state_next = c_st_parity;
`else
          w_state_next = c_st_stop;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      c_st_parity: if (w_bit_end) w_state_next = c_st_stop;
`endif
      c_st_stop:   if (w_bit_end) w_state_next = w_take ? c_st_start : c_st_idle;
      default:     w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    fifo_read    = w_take && reset;
    tx_done_tick = (r_state == c_st_stop) && w_bit_end;
    w_tx_next    = r_tx;
    case (r_state)
      c_st_idle:   if (w_take) w_tx_next = 1'b0;
      c_st_start:  if (w_bit_end) w_tx_next = r_shift[0];
      c_st_data: begin
        if (w_bit_end) w_tx_next = (r_idx == c_idx_last) ? w_after_data : r_shift[1];
      end
`ifdef FIFO_UART_TX_PARITY_EN
      c_st_parity: if (w_bit_end) w_tx_next = 1'b1;
`endif
      c_st_stop:   if (w_bit_end) w_tx_next = !w_take;
      default:     w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= (w_state_next != c_st_idle);
      if (w_take) begin
        r_shift <= fifo_read_data;
        r_cnt   <= '0;
        r_idx   <= '0;
      end else if (r_state != c_st_idle) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
        if (w_bit_end && (r_state == c_st_data)) begin
          r_shift <= r_shift >> 1;
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (w_take) begin
      r_parity <= ^fifo_read_data;
    end
  end
`endif

  assign tx      = r_tx;
  assign tx_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_fifo_uart_tx : directed stimulus, frame-level reference model, per-cycle compare
// Rev 1.0 ; build with FIFO_UART_TX_PARITY_EN to cover the parity frame
// ============================================================================
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS     = DW + 3;
  localparam int LIT_FRAME = 44;
  localparam logic [NBITS-1:0] LIT_A5 = 11'h54A;
  localparam logic [NBITS-1:0] LIT_FF = 11'h5FE;
  localparam logic [NBITS-1:0] LIT_5A = 11'h4B4;
`else
  localparam int NBITS     = DW + 2;
  localparam int LIT_FRAME = 40;
  localparam logic [NBITS-1:0] LIT_A5 = 10'h34A;
  localparam logic [NBITS-1:0] LIT_FF = 10'h3FE;
  localparam logic [NBITS-1:0] LIT_5A = 10'h2B4;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_read_data;
  logic          fifo_read;
  logic          tx;
  logic          tx_busy;
  logic          tx_done_tick;

  fifo_uart_tx #(.DATA_SIZE(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read      (fifo_read),
    .tx             (tx),
    .tx_busy        (tx_busy),
    .tx_done_tick   (tx_done_tick)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] q[$];
  logic          pop_pend = 1'b0;
  logic          chk_en = 1'b0;
  int            cyc = 0;

  logic             m_active = 1'b0;
  int               m_pos = 0;
  logic [NBITS-1:0] m_bits = '1;
  logic             exp_read, exp_tx, exp_done;

  int               n_pops = 0, n_done = 0, busy_cycles = 0, low_cycles = 0;
  int               first_pop = 0, last_pop = -100000, done_cyc = 0;
  logic [NBITS-1:0] cap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NBITS-1:0] frame_of(input logic [DW-1:0] w);
`ifdef FIFO_UART_TX_PARITY_EN
    return {1'b1, ^w, w, 1'b0};
`else
    return {1'b1, w, 1'b0};
`endif
  endfunction

  // Reference: a frame is a fixed bit pattern held CPB cycles per bit; a new word is
  // taken when the FIFO is non-empty and the line is idle or in its last frame cycle.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      exp_read = reset && (q.size() > 0) && (!m_active || m_pos == FRAME - 1);
      exp_tx   = m_active ? m_bits[m_pos / CPB] : 1'b1;
      exp_done = m_active && (m_pos == FRAME - 1);
      check("fifo_read", {31'b0, fifo_read}, {31'b0, exp_read});
      check("tx", {31'b0, tx}, {31'b0, exp_tx});
      check("tx_busy", {31'b0, tx_busy}, {31'b0, m_active});
      check("tx_done_tick", {31'b0, tx_done_tick}, {31'b0, exp_done});

      if (fifo_read === 1'b1) begin
        n_pops++;
        if (n_pops == 1) first_pop = cyc;
        last_pop = cyc;
        cap = '0;
      end
      if (tx_done_tick === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      if (tx_busy === 1'b1) busy_cycles++;
      if (tx === 1'b0) low_cycles++;
      if (cyc > last_pop && cyc - last_pop <= FRAME && (cyc - last_pop) % CPB == 2)
        cap[(cyc - last_pop - 2) / CPB] = tx;

      if (!reset) begin
        m_active = 1'b0;
      end else if (exp_read) begin
        m_bits   = frame_of(q[0]);
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else m_pos++;
      end
    end
    pop_pend = (fifo_read === 1'b1);
  end

  task automatic drive();
    fifo_empty     = (q.size() == 0);
    fifo_read_data = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pend && q.size() > 0) void'(q.pop_front());
    drive();
  endtask

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    drive();
  endtask

  task automatic clear_stats();
    n_pops = 0;
    n_done = 0;
    busy_cycles = 0;
    low_cycles = 0;
  endtask

  initial begin
    reset = 1'b0;
    q.push_back(8'h11);
    drive();
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("reset_no_pop", n_pops, 0);
    check("reset_tx_idle", {31'b0, tx}, 1);
    check("reset_not_busy", {31'b0, tx_busy}, 0);

    reset = 1'b1;
    clear_stats();
    repeat (FRAME + 5) tick();
    check("release_one_pop", n_pops, 1);
    check("release_one_done", n_done, 1);

    clear_stats();
    push(8'hA5);
    repeat (FRAME + 5) tick();
    check("a5_pops", n_pops, 1);
    check("a5_done_count", n_done, 1);
    check("a5_done_offset", done_cyc - last_pop, LIT_FRAME);
    check("a5_frame_bits", {22'b0, cap}, {22'b0, LIT_A5});
    check("a5_busy_len", busy_cycles, LIT_FRAME);

    clear_stats();
    push(8'h00);
    push(8'hFF);
    repeat (2 * FRAME + 5) tick();
    check("b2b_pops", n_pops, 2);
    check("b2b_pop_gap", last_pop - first_pop, LIT_FRAME);
    check("b2b_busy_len", busy_cycles, 2 * LIT_FRAME);
    check("b2b_done_count", n_done, 2);
    check("b2b_ff_bits", {22'b0, cap}, {22'b0, LIT_FF});

    clear_stats();
    repeat (100) tick();
    check("idle_pops", n_pops, 0);
    check("idle_busy", busy_cycles, 0);
    check("idle_tx_low", low_cycles, 0);

    clear_stats();
    push(8'h3C);
    repeat (17) tick();
    reset = 1'b0;
    tick();
    check("abort_tx_high", {31'b0, tx}, 1);
    check("abort_not_busy", {31'b0, tx_busy}, 0);
    reset = 1'b1;
    clear_stats();
    push(8'h5A);
    repeat (FRAME + 5) tick();
    check("after_abort_pops", n_pops, 1);
    check("after_abort_offset", done_cyc - last_pop, LIT_FRAME);
    check("after_abort_bits", {22'b0, cap}, {22'b0, LIT_5A});

`ifdef FIFO_UART_TX_PARITY_EN
    push(8'h07);
    repeat (FRAME + 5) tick();
    check("par07_bit", {31'b0, cap[NBITS-2]}, 1);
    check("par07_len", done_cyc - last_pop, 44);
    push(8'h03);
    repeat (FRAME + 5) tick();
    check("par03_bit", {31'b0, cap[NBITS-2]}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
